// File: rtl/conway_pkg.sv
// rtl/conway_pkg.sv - shared state encoding and default grid dimensions
package conway_pkg;

    localparam int DEFAULT_GRID_WIDTH  = 8;
    localparam int DEFAULT_GRID_HEIGHT = 8;
    localparam int DEFAULT_GEN_WIDTH   = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/grid_row_assembler.sv
// rtl/grid_row_assembler.sv - packs incoming rows into the full grid word
module grid_row_assembler
    import conway_pkg::*;
#(
    parameter int GRID_WIDTH  = DEFAULT_GRID_WIDTH,
    parameter int GRID_HEIGHT = DEFAULT_GRID_HEIGHT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              load_en,
    input  logic [GRID_WIDTH-1:0]             row_in,
    output logic [GRID_WIDTH*GRID_HEIGHT-1:0] grid,
    output logic                              last_row
);

    localparam int ROW_W = (GRID_HEIGHT > 1) ? $clog2(GRID_HEIGHT) : 1;

    logic [ROW_W-1:0] row_cnt;

    assign last_row = (row_cnt == ROW_W'(GRID_HEIGHT - 1));

    // Row counter: restarts on clear, advances per accepted row, wraps after the last row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
        end else if (clear) begin
            row_cnt <= '0;
        end else if (load_en) begin
            row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
        end
    end

    // Grid storage: the accepted row lands in the slot selected by the counter, row 0 at the LSBs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid <= '0;
        end else if (load_en) begin
            for (int i = 0; i < GRID_HEIGHT; i++) begin
                if (row_cnt == ROW_W'(i)) begin
                    grid[i*GRID_WIDTH +: GRID_WIDTH] <= row_in;
                end
            end
        end
    end

endmodule

// File: rtl/grid_sequencer.sv
// rtl/grid_sequencer.sv - load/commit/run controller in front of the grid memory
module grid_sequencer
    import conway_pkg::*;
#(
    parameter int GRID_WIDTH  = DEFAULT_GRID_WIDTH,
    parameter int GRID_HEIGHT = DEFAULT_GRID_HEIGHT,
    parameter int GEN_WIDTH   = DEFAULT_GEN_WIDTH
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              START,
    input  logic                              STOP,
    input  logic                              STEP,
    input  logic [GRID_WIDTH-1:0]             ROW_IN,
    input  logic                              ROW_VALID,
    output logic                              ROW_READY,
    output logic [GRID_WIDTH*GRID_HEIGHT-1:0] INITIAL_OUT,
    output logic                              WRITE_ENABLE,
    output logic                              LOAD_RUN,
    output logic                              BUSY,
    output logic [GEN_WIDTH-1:0]              GENERATION
);

    seq_state_t state;
    seq_state_t next_state;
    logic       row_take;
    logic       load_clear;
    logic       last_row;
    logic       step_write;

    grid_row_assembler #(
        .GRID_WIDTH  (GRID_WIDTH),
        .GRID_HEIGHT (GRID_HEIGHT)
    ) u_assembler (
        .clk      (CLK),
        .rst_n    (RESET),
        .clear    (load_clear),
        .load_en  (row_take),
        .row_in   (ROW_IN),
        .grid     (INITIAL_OUT),
        .last_row (last_row)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode; STOP overrides everything and suppresses row capture
    always_comb begin
        next_state = state;
        row_take   = 1'b0;
        load_clear = 1'b0;
        step_write = 1'b0;
        if (STOP) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        next_state = ST_LOAD;
                        load_clear = 1'b1;
                    end
                end
                ST_LOAD: begin
                    row_take = ROW_VALID & ROW_READY;
                    if (row_take && last_row) begin
                        next_state = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    next_state = ST_RUN;
                end
                ST_RUN: begin
                    step_write = STEP;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Registered outputs, all derived from the upcoming state so they align with it
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ROW_READY    <= 1'b0;
            WRITE_ENABLE <= 1'b0;
            LOAD_RUN     <= 1'b0;
            BUSY         <= 1'b0;
            GENERATION   <= '0;
        end else begin
            ROW_READY    <= (next_state == ST_LOAD);
            BUSY         <= (next_state != ST_IDLE);
            WRITE_ENABLE <= (next_state == ST_COMMIT) || step_write;
            if (next_state == ST_LOAD) begin
                LOAD_RUN <= 1'b0;
            end else if (next_state == ST_RUN) begin
                LOAD_RUN <= 1'b1;
            end
            if (next_state == ST_COMMIT) begin
                GENERATION <= '0;
            end else if (step_write) begin
                GENERATION <= GENERATION + GEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_grid_sequencer.sv
// tb/tb_grid_sequencer.sv - randomized self-checking bench for grid_sequencer
module tb_grid_sequencer;

    localparam int W = 4;
    localparam int H = 4;
    localparam int MS_IDLE   = 0;
    localparam int MS_LOAD   = 1;
    localparam int MS_COMMIT = 2;
    localparam int MS_RUN    = 3;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           START;
    logic           STOP;
    logic           STEP;
    logic [W-1:0]   ROW_IN;
    logic           ROW_VALID;

    logic           row_ready, we, lr, busy;
    logic [W*H-1:0] init_out;
    logic [15:0]    gen;
    logic           row_ready2, we2, lr2, busy2;
    logic [W*H-1:0] init_out2;
    logic [1:0]     gen2;

    int vectors = 0;
    int miscompares = 0;

    int         m_mode;
    int         m_rows;
    logic [3:0] m_grid [H];
    int         m_gen;
    bit         m_we, m_lr, m_ready;

    grid_sequencer #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .GEN_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .STEP(STEP),
        .ROW_IN(ROW_IN), .ROW_VALID(ROW_VALID), .ROW_READY(row_ready),
        .INITIAL_OUT(init_out), .WRITE_ENABLE(we), .LOAD_RUN(lr),
        .BUSY(busy), .GENERATION(gen)
    );

    grid_sequencer #(.GRID_WIDTH(W), .GRID_HEIGHT(H), .GEN_WIDTH(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .STEP(STEP),
        .ROW_IN(ROW_IN), .ROW_VALID(ROW_VALID), .ROW_READY(row_ready2),
        .INITIAL_OUT(init_out2), .WRITE_ENABLE(we2), .LOAD_RUN(lr2),
        .BUSY(busy2), .GENERATION(gen2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W*H-1:0] exp_grid();
        return {m_grid[3], m_grid[2], m_grid[1], m_grid[0]};
    endfunction

    task automatic model_reset();
        m_mode = MS_IDLE; m_rows = 0; m_gen = 0;
        m_we = 0; m_lr = 0; m_ready = 0;
        for (int i = 0; i < H; i++) m_grid[i] = '0;
    endtask

    // Apply one cycle of inputs, advance the behavioural model across the edge, settle 1ns
    task automatic tick(input bit st, input bit sp, input bit stp, input bit v, input logic [W-1:0] r);
        START = st; STOP = sp; STEP = stp; ROW_VALID = v; ROW_IN = r;
        @(posedge CLK);
        if (sp) begin
            m_mode = MS_IDLE; m_we = 0; m_ready = 0;
        end else begin
            case (m_mode)
                MS_IDLE: begin
                    m_we = 0;
                    if (st) begin m_mode = MS_LOAD; m_rows = 0; m_ready = 1; m_lr = 0; end
                end
                MS_LOAD: begin
                    m_we = 0;
                    if (v) begin
                        m_grid[m_rows] = r;
                        m_rows++;
                        if (m_rows == H) begin
                            m_mode = MS_COMMIT; m_we = 1; m_ready = 0; m_gen = 0;
                        end
                    end
                end
                MS_COMMIT: begin m_mode = MS_RUN; m_we = 0; m_lr = 1; end
                default: begin m_we = stp; if (stp) m_gen++; end
            endcase
        end
        #1;
        START = 0; STOP = 0; STEP = 0; ROW_VALID = 0;
    endtask

    task automatic test_reset();
        RESET = 0; START = 0; STOP = 0; STEP = 0; ROW_VALID = 0; ROW_IN = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if ({row_ready, we, lr, busy, init_out, gen} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b we=%b lr=%b busy=%b grid=%h gen=%h expected all 0",
                     row_ready, we, lr, busy, init_out, gen);
        end
        vectors++;
        if ({row_ready2, we2, lr2, busy2, init_out2, gen2} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs2: got rdy=%b we=%b lr=%b busy=%b grid=%h gen=%h expected all 0",
                     row_ready2, we2, lr2, busy2, init_out2, gen2);
        end
        RESET = 1;
    endtask

    task automatic test_load_basic();
        int we_cycles = 0;
        tick(1, 0, 0, 0, '0);
        vectors++;
        if ({row_ready, busy, lr, we} !== 4'b1100) begin
            miscompares++;
            $display("FAIL load_entry: got rdy/busy/lr/we=%b expected 1100", {row_ready, busy, lr, we});
        end
        for (int i = 0; i < H; i++) begin
            tick(0, 0, 0, 1, 4'(1 << i));
            if (we) we_cycles++;
        end
        vectors++;
        if ({we, lr, row_ready} !== 3'b100) begin
            miscompares++;
            $display("FAIL commit_strobe: got we/lr/rdy=%b expected 100", {we, lr, row_ready});
        end
        vectors++;
        if (init_out !== 16'h8421) begin
            miscompares++;
            $display("FAIL load_grid: got %h expected 8421", init_out);
        end
        tick(0, 0, 0, 0, '0);
        if (we) we_cycles++;
        vectors++;
        if (we_cycles !== 1 || lr !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_once: got we_cycles=%0d lr=%b busy=%b expected 1 1 1", we_cycles, lr, busy);
        end
    endtask

    task automatic test_toggle_valid();
        int accepted = 0;
        int we_cycles = 0;
        int commit_at = -1;
        tick(0, 1, 0, 0, '0);
        tick(1, 0, 0, 0, '0);
        for (int c = 0; accepted < H; c++) begin
            bit v = (c % 2 == 0);
            tick(0, 0, 0, v, v ? 4'(1 << accepted) : 4'($urandom));
            if (v) accepted++;
            if (we) begin we_cycles++; commit_at = accepted; end
        end
        tick(0, 0, 0, 0, '0);
        if (we) we_cycles++;
        vectors++;
        if (init_out !== 16'h8421) begin
            miscompares++;
            $display("FAIL toggle_grid: got %h expected 8421", init_out);
        end
        vectors++;
        if (we_cycles !== 1 || commit_at !== H) begin
            miscompares++;
            $display("FAIL toggle_commit: got we_cycles=%0d after_row=%0d expected 1 %0d", we_cycles, commit_at, H);
        end
    endtask

    task automatic test_steps();
        bit pattern [7] = '{1, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 7; i++) begin
            tick(0, 0, pattern[i], 0, '0);
            vectors++;
            if (we !== pattern[i] || lr !== 1'b1) begin
                miscompares++;
                $display("FAIL step_we[%0d]: got we=%b lr=%b expected we=%b lr=1", i, we, lr, pattern[i]);
            end
        end
        vectors++;
        if (gen !== 16'd4 || gen2 !== 2'd0) begin
            miscompares++;
            $display("FAIL step_gen: got %0d/%0d expected 4/0", gen, gen2);
        end
    endtask

    task automatic test_step_stop();
        tick(0, 1, 1, 0, '0);
        vectors++;
        if ({we, busy, lr} !== 3'b001 || gen !== 16'd4) begin
            miscompares++;
            $display("FAIL step_stop: got we/busy/lr=%b gen=%0d expected 001 gen=4", {we, busy, lr}, gen);
        end
    endtask

    task automatic test_stop_partial();
        logic [W-1:0] r [H];
        int we_cycles = 0;
        for (int i = 0; i < H; i++) r[i] = 4'($urandom);
        tick(1, 0, 0, 0, '0);
        tick(0, 0, 0, 1, r[0]);
        tick(0, 0, 0, 1, r[1]);
        tick(0, 1, 0, 0, '0);
        if (we) we_cycles++;
        tick(0, 0, 0, 0, '0);
        if (we) we_cycles++;
        vectors++;
        if (we_cycles !== 0 || {busy, row_ready, lr} !== 3'b000) begin
            miscompares++;
            $display("FAIL stop_partial: got we_cycles=%0d busy/rdy/lr=%b expected 0 000", we_cycles, {busy, row_ready, lr});
        end
        vectors++;
        if (init_out !== {4'h8, 4'h4, r[1], r[0]}) begin
            miscompares++;
            $display("FAIL stop_partial_grid: got %h expected %h", init_out, {4'h8, 4'h4, r[1], r[0]});
        end
        for (int i = 0; i < H; i++) r[i] = 4'($urandom);
        tick(1, 0, 0, 0, '0);
        for (int i = 0; i < H; i++) tick(0, 0, 0, 1, r[i]);
        tick(0, 0, 0, 0, '0);
        vectors++;
        if (init_out !== {r[3], r[2], r[1], r[0]}) begin
            miscompares++;
            $display("FAIL reload_grid: got %h expected %h", init_out, {r[3], r[2], r[1], r[0]});
        end
    endtask

    task automatic test_gen_wrap();
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, '0);
        tick(0, 0, 0, 0, '0);
        vectors++;
        if (gen !== 16'd5 || gen2 !== 2'd1) begin
            miscompares++;
            $display("FAIL gen_wrap: got %0d/%0d expected 5/1", gen, gen2);
        end
    endtask

    task automatic test_reset_commit();
        tick(0, 1, 0, 0, '0);
        tick(1, 0, 0, 0, '0);
        for (int i = 0; i < H; i++) tick(0, 0, 0, 1, 4'($urandom));
        vectors++;
        if (we !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_commit_pre: got we=%b expected 1", we);
        end
        #2 RESET = 0;
        #1;
        model_reset();
        vectors++;
        if ({row_ready, we, lr, busy, init_out, gen, we2, gen2} !== '0) begin
            miscompares++;
            $display("FAIL reset_commit: got rdy=%b we=%b lr=%b busy=%b grid=%h gen=%h expected all 0",
                     row_ready, we, lr, busy, init_out, gen);
        end
        #1 RESET = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit sp = ($urandom_range(0, 31) == 0);
            tick($urandom_range(0, 5) == 0, sp, 1'($urandom_range(0, 1)),
                 sp ? 1'b0 : 1'($urandom_range(0, 1)), 4'($urandom));
            vectors++;
            if ({row_ready, we, lr, busy} !== {m_ready, m_we, m_lr, m_mode != MS_IDLE}) begin
                miscompares++;
                $display("FAIL random_ctrl[%0d]: got rdy/we/lr/busy=%b expected %b", n,
                         {row_ready, we, lr, busy}, {m_ready, m_we, m_lr, m_mode != MS_IDLE});
            end
            vectors++;
            if (init_out !== exp_grid() || gen !== 16'(m_gen) || gen2 !== 2'(m_gen)) begin
                miscompares++;
                $display("FAIL random_data[%0d]: got grid=%h gen=%0d gen2=%0d expected grid=%h gen=%0d gen2=%0d", n,
                         init_out, gen, gen2, exp_grid(), 16'(m_gen), 2'(m_gen));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_toggle_valid();
        test_steps();
        test_step_stop();
        test_stop_partial();
        test_gen_wrap();
        test_reset_commit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grid_sequencer.md
# grid_sequencer

Front-end controller for the Conway grid datapath. Assembles the initial grid from a row-at-a-time valid/ready stream into a full-width word. Commits that word into system memory on the load path, then switches memory to the run path and issues one memory write per requested generation. It sits directly upstream of the system memory block and drives its initial-data, write-enable and load/run select inputs.

## Interface
Parameters:
- GRID_WIDTH, 8, cells per row.
- GRID_HEIGHT, 8, rows per grid; grid word width is GRID_WIDTH*GRID_HEIGHT.
- GEN_WIDTH, 16, width of the generation counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  begin a load; sampled only in IDLE.
- STOP  input  1  abort/finish; return to IDLE from any state.
- STEP  input  1  request one generation; sampled only in RUN.
- ROW_IN  input  GRID_WIDTH  row data.
- ROW_VALID  input  1  ROW_IN valid.
- ROW_READY  output  1  sequencer accepts a row this cycle.
- INITIAL_OUT  output  GRID_WIDTH*GRID_HEIGHT  assembled grid; feeds memory initial input.
- WRITE_ENABLE  output  1  memory write strobe.
- LOAD_RUN  output  1  0 = memory takes INITIAL_OUT, 1 = memory takes grid-calculator output.
- BUSY  output  1  state is not IDLE.
- GENERATION  output  GEN_WIDTH  generations written since the last commit.

## Operation
- Reset values: state IDLE, ROW_READY 0, INITIAL_OUT 0, WRITE_ENABLE 0, LOAD_RUN 0, BUSY 0, GENERATION 0, row counter 0.
- IDLE: all strobes 0. START=1 moves to LOAD and clears the row counter. INITIAL_OUT is not cleared.
- LOAD:
  - ROW_READY=1.
  - On a handshake (ROW_VALID & ROW_READY), ROW_IN is written to INITIAL_OUT[r*GRID_WIDTH +: GRID_WIDTH], where r is the row counter. Row 0 is at the LSBs.
  - r increments on each handshake.
  - The handshake at r=GRID_HEIGHT-1 moves to COMMIT, and ROW_READY drops in the following cycle.
- COMMIT: exactly one cycle.
  - WRITE_ENABLE=1 and LOAD_RUN=0.
  - GENERATION cleared to 0.
  - Next state is RUN.
- RUN:
  - LOAD_RUN=1.
  - STEP=1 at an edge: WRITE_ENABLE=1 for the following cycle and GENERATION+1, both at that same edge.
  - Back-to-back STEP holds WRITE_ENABLE high, one write per cycle.
  - GENERATION wraps at 2^GEN_WIDTH.
- STOP:
  - Has highest priority in every state. The next state is IDLE, with WRITE_ENABLE=0 and ROW_READY=0.
  - STOP in LOAD discards the partial load: memory is not written, and the already-accepted rows remain in INITIAL_OUT.
  - STOP with STEP in the same cycle performs no write.
- START outside IDLE, and STEP outside RUN, are ignored.
- LOAD_RUN holds its last value in IDLE: it is 1 after a completed run and 0 after reset. It is forced to 0 on entry to LOAD.
- Mid-operation reset: immediately returns every output to its reset value, with no write issued.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- START sampled at edge n: ROW_READY=1 from edge n to n+1.
- Last row handshake at edge m:
  - WRITE_ENABLE=1 and LOAD_RUN=0 during cycle m to m+1.
  - Memory captures the grid at edge m+1.
  - LOAD_RUN=1 from edge m+1.
- STEP at edge k: memory captures the grid-calculator output at edge k+1, and GENERATION shows the new count from edge k.
- Minimum load time: GRID_HEIGHT cycles with ROW_VALID held high, plus 1 commit cycle.
- ROW_VALID may drop at any time; the sequencer waits indefinitely.

## Structure
- Shared package conway_pkg holds:
  - The state enum (IDLE, LOAD, COMMIT, RUN).
  - Default grid dimension constants.
- A single sub-module, grid_row_assembler, holds INITIAL_OUT and the row counter. It takes load-enable and clear inputs and outputs last_row.
- The FSM, write strobe and generation counter live in grid_sequencer.

## Test plan
- GRID_WIDTH=GRID_HEIGHT=4. Reset, START, then rows 0x1,0x2,0x4,0x8 with ROW_VALID held → INITIAL_OUT=0x8421, and WRITE_ENABLE=1 with LOAD_RUN=0 for exactly one cycle after the 4th handshake.
- ROW_VALID toggles 1,0,1,0… during LOAD → only valid cycles are accepted, the final INITIAL_OUT is identical, and the commit follows the 4th accepted row.
- In RUN, STEP pulses on 3 consecutive cycles then 1 isolated → WRITE_ENABLE high for 3 cycles then 1 cycle, and GENERATION=4.
- STOP after 2 rows → IDLE, no WRITE_ENABLE, BUSY=0. A new START then reloads from row 0.
- STEP and STOP in the same RUN cycle → no write, GENERATION unchanged, IDLE.
- RESET low during COMMIT → WRITE_ENABLE drops immediately and all outputs are 0. GEN_WIDTH=2 with 5 steps → GENERATION=1.
